usd_responder: RTL
==================

USD_RESPONDER -- requirements
Module: usd_responder

Interface
REQ-001 The block SHALL have exactly one clock and one reset. Reset is synchronous and active-low, and is sampled only on the rising clock edge.
REQ-002 clock  in  1  system clock; clock28 at 28 MHz; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 cs  in  1  SPI chip select from the master; active-low; asynchronous to clock.
REQ-005 ck  in  1  SPI clock, mode 0 (idles low); asynchronous to clock.
REQ-006 mosi  in  1  SPI data from the master; MSB first.
REQ-007 miso  out  1  SPI data to the master; MSB first.
REQ-008 d  in  8  next byte to transmit.
REQ-009 ld  in  1  one-cycle strobe; latches d into the tx holding register.
REQ-010 q  out  8  oldest received byte.
REQ-011 rv  out  1  level; q is valid.
REQ-012 ack  in  1  one-cycle strobe; consumes q.
REQ-013 ovr  out  1  sticky overrun flag.
REQ-014 busy  out  1  high while a transfer is selected (synchronised cs low).

Function
REQ-015 cs, ck and mosi SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised ck only.
REQ-016 Supported SPI timing: ck high and low phases of at least 4 clock cycles each, i.e. up to 3.5 MHz.
REQ-017 FSM states SHALL be IDLE and SHIFT; IDLE->SHIFT on synchronised cs falling; SHIFT->IDLE on synchronised cs rising.
REQ-018 On entry to SHIFT, and after every 8th rising ck edge, the tx shift register SHALL load from the tx holding register, or 0xFF if no ld occurred since the last load; the holding register is then marked empty.
REQ-019 miso SHALL present tx bit 7 within 1 cycle of the load, and SHALL advance one bit on each synchronised falling ck edge.
REQ-020 On each synchronised rising ck edge in SHIFT, the block SHALL shift the synchronised mosi into the rx shift register and increment the 3-bit counter; the counter wraps 7->0.
REQ-021 On the 8th rising edge, the block SHALL push the completed byte to the rx store in the same cycle; rv SHALL rise on the next cycle.
REQ-022 Push when the rx store is full: the new byte is discarded, stored data is unchanged, and ovr is set.
REQ-023 Push and ack in the same cycle: both take effect; no overrun.
REQ-024 ack while rv=0: ignored.
REQ-025 ld during SHIFT overwrites the holding register; it affects only the next byte boundary.
REQ-026 cs rising mid-byte: the partial rx byte is discarded, the counter is cleared, and miso goes to 1; the rx store and holding register are kept.
REQ-027 ovr SHALL clear on synchronised cs falling or on reset; a simultaneous set wins.
REQ-028 In IDLE, miso=1 and ck edges are ignored.

Reset
REQ-029 reset low SHALL force: IDLE, counter=0, miso=1, q=0x00, rv=0, ovr=0, busy=0, tx holding empty, rx store empty, synchroniser flops to idle levels (cs=1, ck=0, mosi=1).
REQ-030 Reset asserted mid-transfer SHALL abort the transfer; after release, the block resumes only on the next cs falling edge.

Configuration
REQ-031 Macro USD_RESPONDER_FIFO_EN.
- Defined: the rx store is a 4-entry FIFO; q shows the head; rv means not empty; full means 4 entries.
- Undefined: the rx store is a single holding register; full means rv=1.
- In both cases, all other behaviour is identical.

Verification
REQ-032 Reset with cs=1; drive one byte of 0xA5 on mosi -> no rv, miso=1 throughout.
REQ-033 ld d=0x3C, cs low, master clocks 8 bits of 0xA5 at 3.5 MHz -> master reads 0x3C on miso; rv=1 with q=0xA5 at most 4 clocks after the 8th rising pin edge.
REQ-034 No ld, transfer 0x00 -> master reads 0xFF; q=0x00.
REQ-035 Three back-to-back bytes 0x11, 0x22, 0x33 without ack:
- FIFO_EN undefined: q=0x11, ovr=1 after byte 2.
- FIFO_EN defined: ack pops 0x11, 0x22, 0x33, ovr=0; a 5th unacked byte sets ovr.
REQ-036 cs rises after 5 bits, then a new full byte 0x81 -> q=0x81 is the only push; counter is restarted.
REQ-037 Reset pulsed low after 3 bits -> rv=0, miso=1, ovr=0; the next full transfer behaves as in REQ-033.

Source files
------------

// File: rtl/usd_responder_if.sv
// SPI pins plus the local byte-stream handshake of the usd_responder block.
// The master modport belongs to the SPI master/host; the slave modport belongs to the responder.
interface usd_responder_if;
    logic       cs;
    logic       ck;
    logic       mosi;
    logic       miso;
    logic [7:0] d;
    logic       ld;
    logic [7:0] q;
    logic       rv;
    logic       ack;
    logic       ovr;
    logic       busy;

    modport master (output cs, ck, mosi, d, ld, ack,
                    input  miso, q, rv, ovr, busy);
    modport slave  (input  cs, ck, mosi, d, ld, ack,
                    output miso, q, rv, ovr, busy);
endinterface

// File: rtl/usd_responder.sv
// SPI mode-0 byte responder with oversampled, synchronised pins and a receive store.
// Define USD_RESPONDER_FIFO_EN for a 4-entry rx FIFO instead of a single holding register.
module usd_responder (
    input  logic           clock,
    input  logic           reset,
    usd_responder_if.slave bus
);

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] cs_sync_q, ck_sync_q, mosi_sync_q;
    logic       cs_prev_q, ck_prev_q;
    logic       cs_fall_s, cs_rise_s, ck_rise_s, ck_fall_s, mosi_s;
    logic       busy_q;

    logic       load_s, rx_shift_s, push_s, tx_shift_s, abort_s;
    logic [2:0] cnt_q;
    logic [7:0] rx_sh_q, rx_byte_s;
    logic [7:0] tx_hold_q, tx_sh_q, tx_next_s;
    logic       tx_full_q, miso_q;
    logic       ovr_q;
    logic       rv_s, full_s, pop_s, accept_s, ovr_set_s;

    assign cs_fall_s = cs_prev_q & ~cs_sync_q[1];
    assign cs_rise_s = ~cs_prev_q & cs_sync_q[1];
    assign ck_rise_s = ~ck_prev_q & ck_sync_q[1];
    assign ck_fall_s = ck_prev_q & ~ck_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign rx_byte_s = {rx_sh_q[6:0], mosi_s};
    assign tx_next_s = tx_full_q ? tx_hold_q : 8'hFF;

    // pin synchronisers and edge-detect history
    always_ff @(posedge clock) begin
        if (!reset) begin
            cs_sync_q   <= 2'b11;
            ck_sync_q   <= 2'b00;
            mosi_sync_q <= 2'b11;
            cs_prev_q   <= 1'b1;
            ck_prev_q   <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], bus.cs};
            ck_sync_q   <= {ck_sync_q[0], bus.ck};
            mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
            cs_prev_q   <= cs_sync_q[1];
            ck_prev_q   <= ck_sync_q[1];
        end
    end

    // state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == SHIFT);
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall_s) state_d = SHIFT; else state_d = IDLE;
            SHIFT:   if (cs_rise_s) state_d = IDLE;  else state_d = SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // per-state datapath strobes; the falling edge right after a byte boundary
    // (cnt_q == 0) is skipped so the freshly loaded bit 7 stays on miso
    always_comb begin
        load_s     = 1'b0;
        rx_shift_s = 1'b0;
        push_s     = 1'b0;
        tx_shift_s = 1'b0;
        abort_s    = 1'b0;
        case (state_q)
            IDLE: load_s = cs_fall_s;
            SHIFT: begin
                if (cs_rise_s) begin
                    abort_s = 1'b1;
                end else begin
                    rx_shift_s = ck_rise_s;
                    push_s     = ck_rise_s & (cnt_q == 3'd7);
                    load_s     = ck_rise_s & (cnt_q == 3'd7);
                    tx_shift_s = ck_fall_s & (cnt_q != 3'd0);
                end
            end
            default: abort_s = 1'b0;
        endcase
    end

    // tx holding register, tx shifter and miso
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_hold_q <= 8'h00;
            tx_full_q <= 1'b0;
            tx_sh_q   <= 8'hFF;
            miso_q    <= 1'b1;
        end else begin
            if (bus.ld) begin
                tx_hold_q <= bus.d;
                tx_full_q <= 1'b1;
            end else if (load_s) begin
                tx_full_q <= 1'b0;
            end
            if (load_s) begin
                tx_sh_q <= tx_next_s;
                miso_q  <= tx_next_s[7];
            end else if (abort_s) begin
                miso_q  <= 1'b1;
            end else if (tx_shift_s) begin
                tx_sh_q <= {tx_sh_q[6:0], 1'b1};
                miso_q  <= tx_sh_q[6];
            end
        end
    end

    // rx shifter and bit counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_sh_q <= 8'h00;
            cnt_q   <= 3'd0;
        end else if (abort_s) begin
            cnt_q   <= 3'd0;
        end else if (rx_shift_s) begin
            rx_sh_q <= rx_byte_s;
            cnt_q   <= cnt_q + 3'd1;
        end
    end

    assign pop_s     = bus.ack & rv_s;
    assign accept_s  = push_s & (~full_s | pop_s);
    assign ovr_set_s = push_s & full_s & ~pop_s;

    // sticky overrun; a set in the same cycle as cs falling wins
    always_ff @(posedge clock) begin
        if (!reset) begin
            ovr_q <= 1'b0;
        end else if (ovr_set_s) begin
            ovr_q <= 1'b1;
        end else if (cs_fall_s) begin
            ovr_q <= 1'b0;
        end
    end

`ifdef USD_RESPONDER_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;

    assign rv_s   = (count_q != 3'd0);
    assign full_s = (count_q == 3'd4);

    // 4-entry rx FIFO; push into a full FIFO is accepted only alongside a pop
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (accept_s) begin
                mem_q[wr_ptr_q] <= rx_byte_s;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, accept_s} - {2'b00, pop_s};
        end
    end

    assign bus.q = mem_q[rd_ptr_q];
`else
    logic [7:0] q_q;
    logic       rv_q;

    assign rv_s   = rv_q;
    assign full_s = rv_q;

    // single-byte rx holding register
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_q  <= 8'h00;
            rv_q <= 1'b0;
        end else if (accept_s) begin
            q_q  <= rx_byte_s;
            rv_q <= 1'b1;
        end else if (pop_s) begin
            rv_q <= 1'b0;
        end
    end

    assign bus.q = q_q;
`endif

    assign bus.rv   = rv_s;
    assign bus.miso = miso_q;
    assign bus.ovr  = ovr_q;
    assign bus.busy = busy_q;

endmodule
